// File: rtl/mdu_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
// The EX-stage side uses the master modport; the unit itself uses slave.
interface mdu_if;
    logic        start;
    logic [2:0]  md_op;
    logic        en;
    logic [31:0] dataRs;
    logic [31:0] dataRt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, en, dataRs, dataRt,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, en, dataRs, dataRt,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Multi-cycle MIPS-style multiply/divide unit.
// The result is computed at issue, held in shadow registers, and committed to HI/LO when the busy countdown expires.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      shadow_hi;
    logic [31:0]      shadow_lo;
    logic             shadow_valid;

    logic             op_valid;
    logic             accept;
    logic [63:0]      mul_signed;
    logic [63:0]      mul_unsigned;
    logic             rs_neg;
    logic             rt_neg;
    logic [31:0]      rs_mag;
    logic [31:0]      rt_mag;
    logic [31:0]      rt_mag_safe;
    logic [31:0]      rt_safe;
    logic [31:0]      sq_mag;
    logic [31:0]      sr_mag;
    logic [31:0]      div_s_q;
    logic [31:0]      div_s_r;
    logic [31:0]      div_u_q;
    logic [31:0]      div_u_r;
    logic             divisor_zero;

    assign op_valid = (bus.md_op >= OP_MULT) && (bus.md_op <= OP_MTLO);
    assign accept   = bus.start && bus.en && (state == IDLE) && op_valid;

    assign bus.busy = (state != IDLE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign mul_signed   = {{32{bus.dataRs[31]}}, bus.dataRs} * {{32{bus.dataRt[31]}}, bus.dataRt};
    assign mul_unsigned = {32'd0, bus.dataRs} * {32'd0, bus.dataRt};

    // Signed division on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        divisor_zero = (bus.dataRt == 32'd0);
        rs_neg       = bus.dataRs[31];
        rt_neg       = bus.dataRt[31];
        rs_mag       = rs_neg ? (32'd0 - bus.dataRs) : bus.dataRs;
        rt_mag       = rt_neg ? (32'd0 - bus.dataRt) : bus.dataRt;
        rt_mag_safe  = divisor_zero ? 32'd1 : rt_mag;
        rt_safe      = divisor_zero ? 32'd1 : bus.dataRt;
        sq_mag       = rs_mag / rt_mag_safe;
        sr_mag       = rs_mag % rt_mag_safe;
        div_s_q      = (rs_neg ^ rt_neg) ? (32'd0 - sq_mag) : sq_mag;
        div_s_r      = rs_neg ? (32'd0 - sr_mag) : sr_mag;
        div_u_q      = bus.dataRs / rt_safe;
        div_u_r      = bus.dataRs % rt_safe;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            shadow_hi    <= 32'd0;
            shadow_lo    <= 32'd0;
            shadow_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.md_op)
                            OP_MULT: begin
                                state        <= MUL;
                                count        <= CNT_W'(MULT_CYCLES);
                                shadow_hi    <= mul_signed[63:32];
                                shadow_lo    <= mul_signed[31:0];
                                shadow_valid <= 1'b1;
                            end
                            OP_MULTU: begin
                                state        <= MUL;
                                count        <= CNT_W'(MULT_CYCLES);
                                shadow_hi    <= mul_unsigned[63:32];
                                shadow_lo    <= mul_unsigned[31:0];
                                shadow_valid <= 1'b1;
                            end
                            OP_DIV: begin
                                state        <= DIV;
                                count        <= CNT_W'(DIV_CYCLES);
                                shadow_hi    <= div_s_r;
                                shadow_lo    <= div_s_q;
                                shadow_valid <= !divisor_zero;
                            end
                            OP_DIVU: begin
                                state        <= DIV;
                                count        <= CNT_W'(DIV_CYCLES);
                                shadow_hi    <= div_u_r;
                                shadow_lo    <= div_u_q;
                                shadow_valid <= !divisor_zero;
                            end
                            OP_MTHI: hi_q <= bus.dataRs;
                            OP_MTLO: lo_q <= bus.dataRs;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    // A zero divisor still burns the full busy time but commits nothing.
                    if (count <= CNT_W'(1)) begin
                        state <= IDLE;
                        count <= '0;
                        if (shadow_valid) begin
                            hi_q <= shadow_hi;
                            lo_q <= shadow_lo;
                        end
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases followed by random traffic,
// all compared every cycle against an arithmetic reference model.
module tb_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Reference model: architectural HI/LO, pending result, remaining busy cycles.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    bit          p_valid;
    int          rem;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge(input bit st, input logic [2:0] op, input bit e,
                             input logic [31:0] rs, input logic [31:0] rt, input bit r);
        int signed    ra;
        int signed    rb;
        longint       sa;
        longint       sb;
        longint       res;
        longint       rres;
        logic [63:0]  ua;
        logic [63:0]  ub;
        logic [63:0]  ures;
        ra = rs;
        rb = rt;
        sa = ra;
        sb = rb;
        ua = {32'd0, rs};
        ub = {32'd0, rt};
        if (r) begin
            m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_valid = 0; rem = 0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0 && p_valid) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (st && e && op >= 3'd1 && op <= 3'd6) begin
            case (op)
                3'd1: begin res = sa * sb; p_hi = res[63:32]; p_lo = res[31:0]; p_valid = 1; rem = MC; end
                3'd2: begin ures = ua * ub; p_hi = ures[63:32]; p_lo = ures[31:0]; p_valid = 1; rem = MC; end
                3'd3: begin
                    rem = DC;
                    p_valid = (rt != 0);
                    if (rt != 0) begin
                        res = sa / sb; rres = sa % sb;
                        p_lo = res[31:0]; p_hi = rres[31:0];
                    end
                end
                3'd4: begin
                    rem = DC;
                    p_valid = (rt != 0);
                    if (rt != 0) begin
                        ures = ua / ub; p_lo = ures[31:0];
                        ures = ua % ub; p_hi = ures[31:0];
                    end
                end
                3'd5: m_hi = rs;
                default: m_lo = rs;
            endcase
        end
    endtask

    task automatic applyStimulus(input bit st, input logic [2:0] op, input bit e,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input bit r, input string tag);
        logic exp_busy;
        bus.start  = st;
        bus.md_op  = op;
        bus.en     = e;
        bus.dataRs = rs;
        bus.dataRt = rt;
        rst        = r;
        @(posedge clk);
        modelEdge(st, op, e, rs, rt, r);
        @(negedge clk);
        exp_busy = (rem > 0);
        checkOutput({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, exp_busy});
        checkOutput({tag, ".hi"}, bus.hi, m_hi);
        checkOutput({tag, ".lo"}, bus.lo, m_lo);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 1'b1, 32'd0, 32'd0, 1'b0, tag);
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_valid = 0; rem = 0;
        bus.start = 0; bus.md_op = 0; bus.en = 1; bus.dataRs = 0; bus.dataRt = 0; rst = 1;
        @(negedge clk);

        // Reset, with a start present that must be overridden.
        applyStimulus(1'b1, 3'd1, 1'b1, 32'd7, 32'd9, 1'b1, "reset");
        applyStimulus(1'b0, 3'd0, 1'b1, 32'd0, 32'd0, 1'b1, "reset");
        checkOutput("reset_hi", bus.hi, 32'd0);

        // Signed multiply.
        applyStimulus(1'b1, 3'd1, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
        idle(MC, "mult_wait");
        checkOutput("mult_hi", bus.hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", bus.lo, 32'hFFFF_FFFA);

        // Unsigned multiply issued back-to-back via the step right after busy fell.
        applyStimulus(1'b1, 3'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu");
        idle(MC, "multu_wait");
        checkOutput("multu_hi", bus.hi, 32'hFFFF_FFFE);
        checkOutput("multu_lo", bus.lo, 32'h0000_0001);

        // Signed divide, then divide by zero leaves HI/LO untouched.
        applyStimulus(1'b1, 3'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
        idle(DC, "div_wait");
        checkOutput("div_lo", bus.lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", bus.hi, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 3'd4, 1'b1, 32'd7, 32'd0, 1'b0, "divu0");
        idle(DC, "divu0_wait");
        checkOutput("divu0_lo", bus.lo, 32'hFFFF_FFFD);

        // Overflow case of signed divide.
        applyStimulus(1'b1, 3'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        idle(DC, "div_ovf_wait");
        checkOutput("div_ovf_lo", bus.lo, 32'h8000_0000);
        checkOutput("div_ovf_hi", bus.hi, 32'h0000_0000);

        // Requests during busy and with en=0 are ignored.
        applyStimulus(1'b1, 3'd1, 1'b1, 32'd6, 32'd7, 1'b0, "ign_mult");
        applyStimulus(1'b1, 3'd5, 1'b1, 32'd1, 32'd0, 1'b0, "ign_mthi");
        applyStimulus(1'b1, 3'd3, 1'b0, 32'd100, 32'd3, 1'b0, "ign_div");
        idle(MC - 2, "ign_wait");
        applyStimulus(1'b1, 3'd1, 1'b0, 32'd9, 32'd9, 1'b0, "ign_en0");
        idle(2, "ign_after");
        checkOutput("ign_lo", bus.lo, 32'd42);
        checkOutput("ign_hi", bus.hi, 32'd0);

        // Move-to HI/LO take effect immediately without busy.
        applyStimulus(1'b1, 3'd5, 1'b1, 32'h1234_5678, 32'd0, 1'b0, "mthi");
        applyStimulus(1'b1, 3'd6, 1'b1, 32'hCAFE_BABE, 32'd0, 1'b0, "mtlo");
        checkOutput("mthi_hi", bus.hi, 32'h1234_5678);
        checkOutput("mtlo_lo", bus.lo, 32'hCAFE_BABE);

        // Reset in the fourth busy cycle discards the divide.
        applyStimulus(1'b1, 3'd3, 1'b1, 32'd100, 32'd7, 1'b0, "rstdiv");
        idle(3, "rstdiv_busy");
        applyStimulus(1'b0, 3'd0, 1'b1, 32'd0, 32'd0, 1'b1, "rstdiv_rst");
        idle(DC, "rstdiv_after");
        checkOutput("rstdiv_lo", bus.lo, 32'd0);

        // Random traffic, including en toggling during busy and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 6) != 0), pickVal(), pickVal(),
                          ($urandom_range(0, 99) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port start  input  1  EX stage issues the op on md_op this cycle.
REQ-006 SHALL have port md_op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none.
REQ-007 SHALL have port en  input  1  issue permit; 0 when the EX instruction is being flushed by an exception or interrupt.
REQ-008 SHALL have port dataRs  input  32  forwarded rs operand (dividend / multiplicand / MTHI/MTLO source).
REQ-009 SHALL have port dataRt  input  32  forwarded rt operand (divisor / multiplier).
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port hi  output  32  architectural HI.
REQ-012 SHALL have port lo  output  32  architectural LO.

Function
REQ-013 SHALL accept an op only at a rising edge where start=1, en=1, busy=0 and md_op is 1..6; otherwise the request is ignored with no state change.
REQ-014 SHALL use FSM states IDLE, MUL, DIV; IDLE->MUL on accepted 1/2, IDLE->DIV on accepted 3/4, MUL/DIV->IDLE when the cycle counter expires.
REQ-015 SHALL latch the full result into shadow registers at the accept edge and load counter with MULT_CYCLES or DIV_CYCLES.
REQ-016 SHALL drive busy=1 for exactly MULT_CYCLES (resp. DIV_CYCLES) cycles following the accept edge, busy being a registered state!=IDLE.
REQ-017 SHALL commit shadow results to hi/lo on the edge that returns the FSM to IDLE, so new hi/lo and busy=0 first appear in the same cycle.
REQ-018 SHALL hold hi/lo at their previous values throughout the busy interval.
REQ-019 MULT: {hi,lo} = signed 64-bit product of dataRs and dataRt; MULTU: unsigned 64-bit product.
REQ-020 DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-021 SHALL for DIV 0x80000000 / 0xFFFFFFFF produce lo=0x80000000, hi=0x00000000.
REQ-022 SHALL for divisor 0 (DIV or DIVU) still run DIV_CYCLES busy cycles and leave hi/lo unchanged at commit.
REQ-023 MTHI SHALL write dataRs to hi (MTLO to lo) at the accept edge, FSM stays IDLE, busy stays 0.
REQ-024 SHALL ignore start while busy=1 (hazard unit stalls EX); a running op is never aborted or restarted by a later start.
REQ-025 SHALL accept a new op in the very cycle busy first reads 0 (back-to-back issue).
REQ-026 SHALL not depend on en after the accept edge; an in-flight op always completes.

Reset
REQ-027 rst=1 at a rising edge SHALL force FSM IDLE, counter 0, busy=0, hi=0, lo=0, shadow registers 0, overriding start.
REQ-028 rst asserted mid-operation SHALL discard the in-flight result; no commit occurs afterward.
REQ-029 All outputs SHALL be 0 from the first edge with rst=1 until an accepted op changes them.

Verification
REQ-030 MULT dataRs=0xFFFFFFFE, dataRt=3 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA with busy=0.
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 DIV 0xFFFFFFF9 / 2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 7 / 0 -> 10 busy cycles, hi/lo unchanged.
REQ-033 MULT accepted, MTHI 0x1 and DIV issued during busy, and MULT with en=0 in IDLE -> all ignored; only first MULT result committed.
REQ-034 MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle, busy=0 throughout; MTLO 0xCAFEBABE -> lo likewise.
REQ-035 DIV started, rst=1 in its 4th busy cycle -> next cycle busy=0, hi=lo=0, no later commit.
